// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes and debounces the load button and address
// switches, producing a single-cycle load strobe (with optional hold-to-repeat),
// a glitch-free address bus and a strobe marking each settled address change.
module input_conditioner #(
  parameter int ADDR_W              = 4,
  parameter int DEBOUNCE_CYCLES     = 1_000_000,
  parameter int REPEAT_EN           = 1,
  parameter int REPEAT_DELAY_CYCLES = 50_000_000,
  parameter int REPEAT_RATE_CYCLES  = 20_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_raw,
  input  logic [ADDR_W-1:0] sw_raw,
  output logic              load_pulse,
  output logic              btn_level,
  output logic [ADDR_W-1:0] address,
  output logic              addr_changed
);

  localparam int DCNT_W = 20;
  localparam logic [DCNT_W-1:0] DEB_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);

  // Repeat counter must hold the larger of the two repeat intervals.
  localparam int RMAX   = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                          REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int RCNT_W = $clog2(RMAX);
  localparam logic [RCNT_W-1:0] DELAY_LAST = RCNT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RCNT_W-1:0] RATE_LAST  = RCNT_W'(REPEAT_RATE_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  logic              btn_s1_q, btn_s_q;
  logic [ADDR_W-1:0] sw_s1_q, sw_s_q;

  logic [DCNT_W-1:0] bcnt_q, bcnt_d;
  logic              btn_level_q, btn_level_d;
  logic              btn_rise, btn_fall;

  logic [ADDR_W-1:0] sw_cand_q, sw_cand_d;
  logic [DCNT_W-1:0] scnt_q, scnt_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              addr_changed_q, addr_changed_d;

  logic [1:0]        state_q, state_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              load_pulse_q, load_pulse_d;

  // Two-stage synchronizers so no raw pin reaches the debounce logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_q <= 1'b0;
      btn_s_q  <= 1'b0;
      sw_s1_q  <= '0;
      sw_s_q   <= '0;
    end else begin
      btn_s1_q <= btn_raw;
      btn_s_q  <= btn_s1_q;
      sw_s1_q  <= sw_raw;
      sw_s_q   <= sw_s1_q;
    end
  end

  // Button debounce: accept a new level after DEBOUNCE_CYCLES differing samples.
  always_comb begin
    bcnt_d      = bcnt_q;
    btn_level_d = btn_level_q;
    btn_rise    = 1'b0;
    btn_fall    = 1'b0;
    if (btn_s_q == btn_level_q) begin
      bcnt_d = '0;
    end else if (bcnt_q == DEB_LAST) begin
      btn_level_d = btn_s_q;
      bcnt_d      = '0;
      btn_rise    = btn_s_q;
      btn_fall    = ~btn_s_q;
    end else begin
      bcnt_d = bcnt_q + 1'b1;
    end
  end

  // Switch debounce: the whole vector must hold one value before it is adopted.
  always_comb begin
    sw_cand_d      = sw_cand_q;
    scnt_d         = scnt_q;
    address_d      = address_q;
    addr_changed_d = 1'b0;
    if (sw_s_q != sw_cand_q) begin
      sw_cand_d = sw_s_q;
      scnt_d    = '0;
    end else if (sw_cand_q != address_q) begin
      if (scnt_q == DEB_LAST) begin
        address_d      = sw_cand_q;
        addr_changed_d = 1'b1;
        scnt_d         = '0;
      end else begin
        scnt_d = scnt_q + 1'b1;
      end
    end else begin
      scnt_d = '0;
    end
  end

  // Pulse FSM: one strobe per press, then optional delayed auto-repeat.
  // A release always wins over a repeat pulse due in the same cycle.
  always_comb begin
    state_d      = state_q;
    rcnt_d       = rcnt_q;
    load_pulse_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (btn_rise) begin
          load_pulse_d = 1'b1;
          state_d      = S_HOLD;
          rcnt_d       = '0;
        end
      end
      S_HOLD: begin
        if (btn_fall) begin
          state_d = S_IDLE;
          rcnt_d  = '0;
        end else if (REPEAT_EN != 0) begin
          if (rcnt_q == DELAY_LAST) begin
            load_pulse_d = 1'b1;
            state_d      = S_REPEAT;
            rcnt_d       = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
      end
      S_REPEAT: begin
        if (btn_fall) begin
          state_d = S_IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == RATE_LAST) begin
          load_pulse_d = 1'b1;
          rcnt_d       = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        rcnt_d  = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q         <= '0;
      btn_level_q    <= 1'b0;
      sw_cand_q      <= '0;
      scnt_q         <= '0;
      address_q      <= '0;
      addr_changed_q <= 1'b0;
      state_q        <= S_IDLE;
      rcnt_q         <= '0;
      load_pulse_q   <= 1'b0;
    end else begin
      bcnt_q         <= bcnt_d;
      btn_level_q    <= btn_level_d;
      sw_cand_q      <= sw_cand_d;
      scnt_q         <= scnt_d;
      address_q      <= address_d;
      addr_changed_q <= addr_changed_d;
      state_q        <= state_d;
      rcnt_q         <= rcnt_d;
      load_pulse_q   <= load_pulse_d;
    end
  end

  assign load_pulse   = load_pulse_q;
  assign btn_level    = btn_level_q;
  assign address      = address_q;
  assign addr_changed = addr_changed_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Testbench for input_conditioner: directed scenarios plus randomized segments,
// checked every cycle against a window-based behavioural model.
module tb_input_conditioner;

  localparam int AW   = 4;
  localparam int D    = 4;
  localparam int DEL  = 10;
  localparam int RATE = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          btn_raw;
  logic [AW-1:0] sw_raw;

  logic          load_pulse, btn_level, addr_changed;
  logic [AW-1:0] address;
  logic          nr_load_pulse, nr_btn_level, nr_addr_changed;
  logic [AW-1:0] nr_address;

  input_conditioner #(
    .ADDR_W(AW), .DEBOUNCE_CYCLES(D), .REPEAT_EN(1),
    .REPEAT_DELAY_CYCLES(DEL), .REPEAT_RATE_CYCLES(RATE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .load_pulse(load_pulse), .btn_level(btn_level),
    .address(address), .addr_changed(addr_changed)
  );

  input_conditioner #(
    .ADDR_W(AW), .DEBOUNCE_CYCLES(D), .REPEAT_EN(0),
    .REPEAT_DELAY_CYCLES(DEL), .REPEAT_RATE_CYCLES(RATE)
  ) dut_nr (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .load_pulse(nr_load_pulse), .btn_level(nr_btn_level),
    .address(nr_address), .addr_changed(nr_addr_changed)
  );

  always #5 clk = ~clk;

  // Sample history: index = edge number since start, samples at or before
  // the last reset release (base) read back as 0.
  logic          bh [0:4095];
  logic [AW-1:0] sh [0:4095];
  int n    = 0;
  int base = 0;
  int pass_cnt  = 0;
  int total_cnt = 0;

  // Model state
  logic          m_level = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  int            m_t0    = 0;
  logic          e_pulse, e_pulse_nr, e_chg;

  function automatic logic bget(input int k);
    if (k <= base) return 1'b0;
    return bh[k];
  endfunction

  function automatic logic [AW-1:0] sget(input int k);
    if (k <= base) return '0;
    return sh[k];
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, n - base, obs, exp);
  endtask

  // One clock: drive inputs, let the DUT sample them, advance the model, compare.
  task automatic step(input logic b, input logic [AW-1:0] s);
    logic          all_diff;
    logic          same;
    logic [AW-1:0] x;
    btn_raw = b;
    sw_raw  = s;
    @(posedge clk);
    #1;
    n = n + 1;
    bh[n] = b;
    sh[n] = s;
    e_pulse = 1'b0; e_pulse_nr = 1'b0; e_chg = 1'b0;

    // The logic at edge n sees the raw value sampled two edges earlier.
    // A level is accepted once D consecutive such samples disagree with it.
    all_diff = 1'b1;
    for (int j = 0; j < D; j++)
      if (bget(n - 2 - j) == m_level) all_diff = 1'b0;
    if (all_diff) begin
      if (!m_level) begin
        m_level = 1'b1; m_t0 = n; e_pulse = 1'b1; e_pulse_nr = 1'b1;
      end else begin
        m_level = 1'b0;
      end
    end else if (m_level && (n - m_t0) >= DEL && ((n - m_t0 - DEL) % RATE) == 0) begin
      e_pulse = 1'b1;
    end

    // Switches: D+1 identical samples (candidate stage + D count) adopt a new value.
    x = sget(n - 2);
    same = 1'b1;
    for (int j = 0; j <= D; j++)
      if (sget(n - 2 - j) != x) same = 1'b0;
    if (same && x != m_addr) begin
      m_addr = x; e_chg = 1'b1;
    end

    check("load_pulse",      8'(load_pulse),      8'(e_pulse));
    check("btn_level",       8'(btn_level),       8'(m_level));
    check("address",         8'(address),         8'(m_addr));
    check("addr_changed",    8'(addr_changed),    8'(e_chg));
    check("norep_load_pulse", 8'(nr_load_pulse),  8'(e_pulse_nr));
    check("norep_btn_level",  8'(nr_btn_level),   8'(m_level));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_load_pulse"},   8'(load_pulse),   8'h00);
    check({tag, "_btn_level"},    8'(btn_level),    8'h00);
    check({tag, "_address"},      8'(address),      8'h00);
    check({tag, "_addr_changed"}, 8'(addr_changed), 8'h00);
    check({tag, "_norep_pulse"},  8'(nr_load_pulse), 8'h00);
  endtask

  // Release reset between edges and restart the model from its reset state.
  task automatic release_reset();
    @(negedge clk);
    rst_n   = 1'b1;
    base    = n;
    m_level = 1'b0;
    m_addr  = '0;
    m_t0    = 0;
  endtask

  initial begin
    logic          rb;
    logic [AW-1:0] rs;
    int            len;

    rst_n = 1'b0; btn_raw = 1'b0; sw_raw = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    release_reset();

    $display("scenario 1: clean press and release");
    for (int i = 0; i < 8; i++)  step(1'b1, 4'h0);
    for (int i = 0; i < 12; i++) step(1'b0, 4'h0);

    $display("scenario 2: bounce rejection");
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'h0); step(1'b1, 4'h0);
      step(1'b0, 4'h0); step(1'b0, 4'h0);
    end
    for (int i = 0; i < 12; i++) step(1'b1, 4'h0);
    for (int i = 0; i < 12; i++) step(1'b0, 4'h0);

    $display("scenario 3/4: hold-to-repeat, repeat disabled instance alongside");
    for (int i = 0; i < 40; i++) step(1'b1, 4'h0);
    for (int i = 0; i < 15; i++) step(1'b0, 4'h0);

    $display("scenario 5: switch step and glitch");
    for (int i = 0; i < 10; i++) step(1'b0, 4'hA);
    step(1'b0, 4'h3); step(1'b0, 4'h3);
    for (int i = 0; i < 10; i++) step(1'b0, 4'hA);

    $display("scenario 6: reset during repeat");
    for (int i = 0; i < 25; i++) step(1'b1, 4'h5);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    release_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 4'h5);
    for (int i = 0; i < 10; i++) step(1'b0, 4'h5);

    $display("scenario 7: randomized segments");
    rs = 4'h5;
    for (int seg = 0; seg < 60; seg++) begin
      rb  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) rs = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) step(rb, rs);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
